// File: rtl/hsiao_pkg.sv
// Shared constants for the Hsiao (13,8) SEC-DED code and the scrubber FSM encoding.
package hsiao_pkg;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned ChkWidth  = 5;
  localparam int unsigned CwWidth   = DataWidth + ChkWidth;

  // Column i is the syndrome contribution of codeword bit i (d0..d7, then c0..c4).
  localparam logic [CwWidth-1:0][ChkWidth-1:0] HMatrix = {
    5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001,
    5'b11001, 5'b10110, 5'b10101, 5'b10011,
    5'b01110, 5'b01101, 5'b01011, 5'b00111
  };

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StEv,
    StWb,
    StAdv,
    StDone
  } scrub_state_e;

endpackage

// File: rtl/hsiao_mem_scrubber_if.sv
// Codeword memory port: the scrubber drives address/write side, the memory returns read data.
interface hsiao_mem_scrubber_if
  import hsiao_pkg::*;
#(
  parameter int unsigned AW = 4
);

  logic [AW-1:0]      mem_addr;
  logic               mem_wr_en;
  logic [CwWidth-1:0] mem_wdata;
  logic [CwWidth-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wr_en,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/hsiao_decoder_13_8.sv
// Combinational Hsiao (13,8) decoder: syndrome, single-error correction, uncorrectable detection.
module hsiao_decoder_13_8
  import hsiao_pkg::*;
(
  input  logic [CwWidth-1:0]  codeword_i,
  output logic [ChkWidth-1:0] syndrome_o,
  output logic                correctable_o,
  output logic                uncorrectable_o,
  output logic [CwWidth-1:0]  corrected_o
);

  logic [ChkWidth-1:0] syn;
  logic [CwWidth-1:0]  match;

  always_comb begin
    syn = '0;
    for (int i = 0; i < CwWidth; i++) begin
      if (codeword_i[i]) begin
        syn = syn ^ HMatrix[i];
      end
    end
    // Columns are distinct and nonzero, so at most one bit can match.
    match = '0;
    for (int i = 0; i < CwWidth; i++) begin
      match[i] = (syn == HMatrix[i]);
    end
  end

  assign syndrome_o      = syn;
  assign correctable_o   = |match;
  assign uncorrectable_o = (syn != '0) && !(|match);
  assign corrected_o     = codeword_i ^ match;

endmodule

// File: rtl/hsiao_mem_scrubber.sv
// Sweeps a codeword memory once per start, writing back single-bit corrections and
// counting corrected and uncorrectable words.
module hsiao_mem_scrubber
  import hsiao_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 pause_i,
  hsiao_mem_scrubber_if.master mem_bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AW:0]          corr_cnt_o,
  output logic [AW:0]          uncorr_cnt_o,
  output logic [AW-1:0]        uncorr_addr_o
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [AW-1:0] AddrOne  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CntOne   = {{AW{1'b0}}, 1'b1};

  scrub_state_e       state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [CwWidth-1:0] word_q, word_d;
  logic [AW:0]        corr_q, corr_d;
  logic [AW:0]        uncorr_q, uncorr_d;
  logic [AW-1:0]      uaddr_q, uaddr_d;

  logic [ChkWidth-1:0] syndrome;
  logic                correctable;
  logic                uncorrectable;
  logic [CwWidth-1:0]  corrected;

  hsiao_decoder_13_8 u_decoder (
    .codeword_i     (word_q),
    .syndrome_o     (syndrome),
    .correctable_o  (correctable),
    .uncorrectable_o(uncorrectable),
    .corrected_o    (corrected)
  );

  // Port outputs kept apart from next-state logic: read data depends on mem_addr.
  always_comb begin
    mem_bus.mem_addr  = '0;
    mem_bus.mem_wr_en = 1'b0;
    mem_bus.mem_wdata = '0;
    if (state_q == StRd) begin
      mem_bus.mem_addr = addr_q;
    end else if (state_q == StWb) begin
      mem_bus.mem_addr  = addr_q;
      mem_bus.mem_wr_en = 1'b1;
      mem_bus.mem_wdata = corrected;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    uaddr_d  = uaddr_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          corr_d   = '0;
          uncorr_d = '0;
          addr_d   = '0;
          state_d  = StRd;
        end
      end
      StRd: begin
        if (!pause_i) begin
          word_d  = mem_bus.mem_rdata;
          state_d = StEv;
        end
      end
      StEv: begin
        state_d = StAdv;
        if (syndrome != '0) begin
          if (correctable) begin
            corr_d  = corr_q + CntOne;
            state_d = StWb;
          end else if (uncorrectable) begin
            uncorr_d = uncorr_q + CntOne;
            uaddr_d  = addr_q;
          end
        end
      end
      StWb: state_d = StAdv;
      StAdv: begin
        if (addr_q == LastAddr) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + AddrOne;
          state_d = StRd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      word_q   <= '0;
      corr_q   <= '0;
      uncorr_q <= '0;
      uaddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      word_q   <= word_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      uaddr_q  <= uaddr_d;
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign corr_cnt_o    = corr_q;
  assign uncorr_cnt_o  = uncorr_q;
  assign uncorr_addr_o = uaddr_q;

endmodule

// File: tb/tb_hsiao_mem_scrubber.sv
// Scrubber bench: memory model plus a reference decoder that finds corrections by trial bit flips.
module tb_hsiao_mem_scrubber;
  import hsiao_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int          Limit = 300;
  localparam logic [4:0] HCOL [13] = '{5'b00111, 5'b01011, 5'b01101, 5'b01110, 5'b10011,
                                       5'b10101, 5'b10110, 5'b11001, 5'b00001, 5'b00010,
                                       5'b00100, 5'b01000, 5'b10000};

  logic          clk = 1'b0;
  logic          rst, start, pause, load;
  logic          busy, done;
  logic [AW:0]   corr_cnt, uncorr_cnt;
  logic [AW-1:0] uncorr_addr;
  logic [12:0]   mem [DEPTH];
  logic [12:0]   img [DEPTH];

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [AW-1:0] exp_uaddr;

  hsiao_mem_scrubber_if #(.AW(AW)) mif ();

  hsiao_mem_scrubber #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .pause_i      (pause),
    .mem_bus      (mif),
    .busy_o       (busy),
    .done_o       (done),
    .corr_cnt_o   (corr_cnt),
    .uncorr_cnt_o (uncorr_cnt),
    .uncorr_addr_o(uncorr_addr)
  );

  always #5 clk = ~clk;

  assign mif.mem_rdata = mem[mif.mem_addr];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
    end else if (mif.mem_wr_en) begin
      mem[mif.mem_addr] <= mif.mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] syn_of(input logic [12:0] cw);
    logic [4:0] s = '0;
    for (int i = 0; i < 13; i++) if (cw[i]) s = s ^ HCOL[i];
    return s;
  endfunction

  function automatic logic [12:0] encode(input logic [7:0] d);
    return {syn_of({5'b0, d}), d};
  endfunction

  task automatic load_image();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic fill_clean();
    for (int a = 0; a < DEPTH; a++) img[a] = 13'h06FF;
  endtask

  task automatic run_sweep(input int pause_addr);
    logic [12:0] exp_img [DEPTH];
    logic [16:0] exp_w[$];
    logic [16:0] got_w[$];
    logic [12:0] cw, one;
    int exp_corr = 0, exp_uncorr = 0, exp_done, n = 0, pause_left = 0;
    bit found, armed;
    one = 13'h0001;
    for (int a = 0; a < DEPTH; a++) begin
      cw = img[a];
      exp_img[a] = cw;
      if (syn_of(cw) != 5'd0) begin
        found = 1'b0;
        for (int b = 0; b < 13; b++) begin
          if (!found && syn_of(cw ^ (one << b)) == 5'd0) begin
            found = 1'b1;
            exp_img[a] = cw ^ (one << b);
          end
        end
        if (found) begin
          exp_corr++;
          exp_w.push_back({AW'(a), exp_img[a]});
        end else begin
          exp_uncorr++;
          exp_uaddr = AW'(a);
        end
      end
    end
    exp_done = 3 * DEPTH + 1 + exp_corr + ((pause_addr >= 0) ? 10 : 0);
    armed = (pause_addr >= 0);
    @(negedge clk) start = 1'b1;
    do begin
      @(posedge clk);
      #1;
      if (n == 0) start = 1'b0;
      n++;
      if (mif.mem_wr_en) got_w.push_back({mif.mem_addr, mif.mem_wdata});
      if (pause_left > 0) begin
        check_eq("pause_hold_addr", 32'(mif.mem_addr), 32'(pause_addr));
        pause_left--;
        if (pause_left == 0) pause = 1'b0;
      end else if (armed && busy && !mif.mem_wr_en && int'(mif.mem_addr) == pause_addr) begin
        pause = 1'b1;
        pause_left = 10;
        armed = 1'b0;
      end
    end while (!done && n < Limit);
    pause = 1'b0;
    check_eq("done_cycle", 32'(n), 32'(exp_done));
    check_eq("busy_at_done", 32'(busy), 32'd1);
    check_eq("corr_cnt", 32'(corr_cnt), 32'(exp_corr));
    check_eq("uncorr_cnt", 32'(uncorr_cnt), 32'(exp_uncorr));
    check_eq("uncorr_addr", 32'(uncorr_addr), 32'(exp_uaddr));
    check_eq("wr_count", 32'(got_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check_eq("wr_entry", 32'(got_w[i]), 32'(exp_w[i]));
    @(posedge clk);
    #1;
    check_eq("done_pulse_end", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("hold_corr_cnt", 32'(corr_cnt), 32'(exp_corr));
    for (int a = 0; a < DEPTH; a++) check_eq("mem_final", 32'(mem[a]), 32'(exp_img[a]));
  endtask

  initial begin
    logic [12:0] cw, one;
    int b1, n;
    one = 13'h0001;
    rst = 1'b1; start = 1'b0; pause = 1'b0; load = 1'b0;
    exp_uaddr = '0;
    fill_clean();
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_wr_en", 32'(mif.mem_wr_en), 32'd0);
    check_eq("rst_addr", 32'(mif.mem_addr), 32'd0);
    check_eq("rst_wdata", 32'(mif.mem_wdata), 32'd0);
    check_eq("rst_counts", 32'({corr_cnt, uncorr_cnt, uncorr_addr}), 32'd0);
    rst = 1'b0;

    load_image();
    run_sweep(-1);
    fill_clean(); img[5] = 13'h06FE; load_image(); run_sweep(-1);
    fill_clean(); img[9] = 13'h06FC; load_image(); run_sweep(-1);
    fill_clean(); img[3] = 13'h07FF; load_image(); run_sweep(-1);
    fill_clean(); img[4] = 13'h06FE; load_image(); run_sweep(7);

    // Abort during the write-back of address 2.
    fill_clean(); img[2] = 13'h06FE; load_image();
    @(negedge clk) start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end while (!(mif.mem_wr_en && mif.mem_addr == 2) && n < Limit);
    check_eq("wb_seen", 32'(n < Limit), 32'd1);
    rst = 1'b1;
    #1;
    exp_uaddr = '0;
    check_eq("abort_wr_en", 32'(mif.mem_wr_en), 32'd0);
    check_eq("abort_addr", 32'(mif.mem_addr), 32'd0);
    check_eq("abort_wdata", 32'(mif.mem_wdata), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_counts", 32'({corr_cnt, uncorr_cnt, uncorr_addr}), 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check_eq("abort_no_write", 32'(mem[2]), 32'h06FE);
    fill_clean(); load_image(); run_sweep(-1);

    for (int s = 0; s < 6; s++) begin
      for (int a = 0; a < DEPTH; a++) begin
        cw = encode(8'($urandom));
        case ($urandom_range(0, 3))
          1: cw = cw ^ (one << $urandom_range(0, 12));
          2: begin
            b1 = $urandom_range(0, 12);
            cw = cw ^ (one << b1) ^ (one << ((b1 + $urandom_range(1, 12)) % 13));
          end
          3: cw = 13'($urandom);
          default: ;
        endcase
        img[a] = cw;
      end
      load_image();
      run_sweep(-1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
